fib_job_driver: RTL and testbench

- Upstream sequencer for the synthesized fib kernel (`main`).
- Accepts jobs (n, a, b, tag) over a valid/ready request channel and loads them into the kernel via r_enable/init_*.
- Waits for the kernel's w_enable and captures its result plus a cycle count.
- Returns responses over a valid/ready channel through a small output FIFO, with a watchdog timeout.

---
 rtl/fib_drv_pkg.sv | 22 ++
 rtl/fib_resp_fifo.sv | 62 ++++++
 rtl/fib_job_driver.sv | 156 +++++++++++++++
 tb/tb_fib_job_driver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_drv_pkg.sv
// Shared types and width defaults for the fib kernel job driver.
package fib_drv_pkg;

  localparam int N_W   = 6;
  localparam int D_W   = 32;
  localparam int TAG_W = 4;
  localparam int CYC_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  typedef struct packed {
    logic [D_W-1:0]   result;
    logic [CYC_W-1:0] cycles;
    logic [TAG_W-1:0] tag;
    logic             timeout;
  } resp_t;

endpackage

// File: rtl/fib_resp_fifo.sv
// Small synchronous FIFO holding completed job responses.
// The head reads as all-zero while the FIFO is empty.
module fib_resp_fifo
  import fib_drv_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = resp_t,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output entry_t           head
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still safe.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  // NOTE: storage is deliberately not reset; the empty flag masks stale entries on head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fib_job_driver.sv
// Sequencer that loads jobs into the fib kernel, waits for completion or
// watchdog expiry, and queues the response for the downstream consumer.
module fib_job_driver
  import fib_drv_pkg::*;
#(
  parameter int N_W        = fib_drv_pkg::N_W,
  parameter int D_W        = fib_drv_pkg::D_W,
  parameter int TAG_W      = fib_drv_pkg::TAG_W,
  parameter int CYC_W      = fib_drv_pkg::CYC_W,
  parameter int MAX_CYCLES = 1024,
  parameter int OUT_DEPTH  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N_W-1:0]   req_n,
  input  logic [D_W-1:0]   req_a,
  input  logic [D_W-1:0]   req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             kern_r_enable,
  output logic             kern_controlArr,
  output logic [N_W-1:0]   kern_init_n,
  output logic [D_W-1:0]   kern_init_a,
  output logic [D_W-1:0]   kern_init_b,
  input  logic             kern_w_enable,
  input  logic [D_W-1:0]   kern_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [D_W-1:0]   resp_result,
  output logic [CYC_W-1:0] resp_cycles,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_timeout,
  output logic             busy
);

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  // Local response layout so that overridden widths stay consistent.
  typedef struct packed {
    logic [D_W-1:0]   result;
    logic [CYC_W-1:0] cycles;
    logic [TAG_W-1:0] tag;
    logic             timeout;
  } entry_t;

  state_t           state;
  state_t           state_n;
  logic [N_W-1:0]   job_n;
  logic [D_W-1:0]   job_a;
  logic [D_W-1:0]   job_b;
  logic [TAG_W-1:0] job_tag;
  logic [CYC_W-1:0] cyc_cnt;
  logic [CYC_W-1:0] cyc_inc;
  logic             accept;
  logic             run_push;
  entry_t           push_data;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  entry_t           fifo_head;

  // Saturating view of the counter as it stands at the end of this RUN cycle.
  assign cyc_inc = (&cyc_cnt) ? cyc_cnt : cyc_cnt + 1'b1;

  // State register, job latch and RUN cycle counter.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      job_n   <= '0;
      job_a   <= '0;
      job_b   <= '0;
      job_tag <= '0;
      cyc_cnt <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        job_n   <= req_n;
        job_a   <= req_a;
        job_b   <= req_b;
        job_tag <= req_tag;
      end
      if (state == LOAD)     cyc_cnt <= '0;
      else if (state == RUN) cyc_cnt <= cyc_inc;
    end
  end

  // Next-state, handshake and kernel-control decode.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n       = state;
    req_ready     = 1'b0;
    accept        = 1'b0;
    kern_r_enable = 1'b1;
    run_push      = 1'b0;
    push_data     = '0;
    case (state)
      IDLE: begin
        // Only one job is ever in flight, so a free slot now guarantees room at completion.
        req_ready = (fifo_count < CNT_W'(OUT_DEPTH));
        accept    = req_valid && req_ready;
        if (accept) state_n = LOAD;
      end
      LOAD: begin
        state_n = RUN;
      end
      RUN: begin
        kern_r_enable = 1'b0;
        // Completion takes priority over a watchdog expiring in the same cycle.
        if (kern_w_enable) begin
          run_push  = 1'b1;
          push_data = '{result: kern_result, cycles: cyc_inc, tag: job_tag, timeout: 1'b0};
          state_n   = IDLE;
        end else if (cyc_inc == CYC_W'(MAX_CYCLES)) begin
          run_push  = 1'b1;
          push_data = '{result: '0, cycles: CYC_W'(MAX_CYCLES), tag: job_tag, timeout: 1'b1};
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign fifo_pop  = resp_ready;
  assign fifo_push = run_push && (!fifo_full || fifo_pop);

  fib_resp_fifo #(
    .DEPTH   (OUT_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (push_data),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign kern_controlArr = 1'b0;
  assign kern_init_n     = job_n;
  assign kern_init_a     = job_a;
  assign kern_init_b     = job_b;
  assign busy            = (state != IDLE);
  assign resp_valid      = !fifo_empty;
  assign resp_result     = fifo_head.result;
  assign resp_cycles     = fifo_head.cycles;
  assign resp_tag        = fifo_head.tag;
  assign resp_timeout    = fifo_head.timeout;

endmodule

// File: tb/tb_fib_job_driver.sv
// Directed bench for fib_job_driver: two instances (default watchdog and a
// short one) each driving a behavioural fib kernel, with a response scoreboard.
module tb_fib_job_driver;
  import fib_drv_pkg::*;

  logic             clk = 1'b0;
  logic             rst          [2];
  logic             req_valid    [2];
  logic             req_ready    [2];
  logic [N_W-1:0]   req_n        [2];
  logic [D_W-1:0]   req_a        [2];
  logic [D_W-1:0]   req_b        [2];
  logic [TAG_W-1:0] req_tag      [2];
  logic             kern_r_enable[2];
  logic             kern_ctrl    [2];
  logic [N_W-1:0]   kern_init_n  [2];
  logic [D_W-1:0]   kern_init_a  [2];
  logic [D_W-1:0]   kern_init_b  [2];
  logic             kern_w_enable[2];
  logic [D_W-1:0]   kern_result  [2];
  logic             resp_valid   [2];
  logic             resp_ready   [2];
  logic [D_W-1:0]   resp_result  [2];
  logic [CYC_W-1:0] resp_cycles  [2];
  logic [TAG_W-1:0] resp_tag     [2];
  logic             resp_timeout [2];
  logic             busy         [2];

  int    checks   = 0;
  int    failures = 0;
  resp_t sb [$];

  always #5 clk = ~clk;

  fib_job_driver #(.MAX_CYCLES(1024)) dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_n(req_n[0]), .req_a(req_a[0]), .req_b(req_b[0]), .req_tag(req_tag[0]),
    .kern_r_enable(kern_r_enable[0]), .kern_controlArr(kern_ctrl[0]),
    .kern_init_n(kern_init_n[0]), .kern_init_a(kern_init_a[0]), .kern_init_b(kern_init_b[0]),
    .kern_w_enable(kern_w_enable[0]), .kern_result(kern_result[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_result(resp_result[0]),
    .resp_cycles(resp_cycles[0]), .resp_tag(resp_tag[0]), .resp_timeout(resp_timeout[0]),
    .busy(busy[0])
  );

  fib_job_driver #(.MAX_CYCLES(20)) dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_n(req_n[1]), .req_a(req_a[1]), .req_b(req_b[1]), .req_tag(req_tag[1]),
    .kern_r_enable(kern_r_enable[1]), .kern_controlArr(kern_ctrl[1]),
    .kern_init_n(kern_init_n[1]), .kern_init_a(kern_init_a[1]), .kern_init_b(kern_init_b[1]),
    .kern_w_enable(kern_w_enable[1]), .kern_result(kern_result[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_result(resp_result[1]),
    .resp_cycles(resp_cycles[1]), .resp_tag(resp_tag[1]), .resp_timeout(resp_timeout[1]),
    .busy(busy[1])
  );

  function automatic logic [D_W-1:0] fib(input int n, input logic [D_W-1:0] a, input logic [D_W-1:0] b);
    logic [D_W-1:0] t;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      b = a;
      a = t;
    end
    return a;
  endfunction

  function automatic int max_cyc(input int g);
    return (g == 0) ? 1024 : 20;
  endfunction

  // Behavioural kernel: w_enable rises on RUN cycle 5n+6 and holds until reloaded.
  for (genvar g = 0; g < 2; g++) begin : g_kern
    int kcnt = 0;
    always @(posedge clk) begin
      if (kern_r_enable[g]) kcnt <= 0;
      else                  kcnt <= kcnt + 1;
    end
    assign kern_w_enable[g] = (kcnt >= 5 * int'(kern_init_n[g]) + 5);
    assign kern_result[g]   = fib(int'(kern_init_n[g]), kern_init_a[g], kern_init_b[g]);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: a handshake seen mid-cycle completes at the next edge.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst[g] && resp_valid[g] && resp_ready[g]) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          resp_t e;
          e = sb.pop_front();
          check("resp_result",  64'(resp_result[g]),  64'(e.result));
          check("resp_cycles",  64'(resp_cycles[g]),  64'(e.cycles));
          check("resp_tag",     64'(resp_tag[g]),     64'(e.tag));
          check("resp_timeout", 64'(resp_timeout[g]), 64'(e.timeout));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int g, input int n, input logic [D_W-1:0] a,
                      input logic [D_W-1:0] b, input logic [TAG_W-1:0] tag);
    logic  seen;
    logic  accepted;
    resp_t e;
    int    cyc;
    accepted     = 1'b0;
    req_valid[g] = 1'b1;
    req_n[g]     = N_W'(n);
    req_a[g]     = a;
    req_b[g]     = b;
    req_tag[g]   = tag;
    for (int i = 0; i < 300 && !accepted; i++) begin
      seen = req_ready[g];
      tick();
      accepted = seen;
    end
    req_valid[g] = 1'b0;
    check("req_accept", 64'(accepted), 64'd1);
    cyc = 5 * n + 6;
    if (cyc <= max_cyc(g)) e = '{result: fib(n, a, b), cycles: CYC_W'(cyc), tag: tag, timeout: 1'b0};
    else                   e = '{result: '0, cycles: CYC_W'(max_cyc(g)), tag: tag, timeout: 1'b1};
    if (accepted) sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_idle(input int g, input int budget);
    for (int i = 0; i < budget && busy[g]; i++) tick();
    check("wait_idle", 64'(busy[g]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; req_valid[g] = 1'b0; resp_ready[g] = 1'b1;
      req_n[g] = '0; req_a[g] = '0; req_b[g] = '0; req_tag[g] = '0;
    end
    tick(2);
    // Reset state, sampled while reset is still asserted.
    check("rst_resp_valid",   64'(resp_valid[0]),    64'd0);
    check("rst_busy",         64'(busy[0]),          64'd0);
    check("rst_r_enable",     64'(kern_r_enable[0]), 64'd1);
    check("rst_resp_result",  64'(resp_result[0]),   64'd0);
    check("rst_resp_cycles",  64'(resp_cycles[0]),   64'd0);
    check("rst_resp_tag",     64'(resp_tag[0]),      64'd0);
    check("rst_init_a",       64'(kern_init_a[0]),   64'd0);
    check("rst_controlArr",   64'(kern_ctrl[0]),     64'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();
    check("idle_req_ready", 64'(req_ready[0]), 64'd1);

    // n=0: result = a, inclusive cycle count 6.
    send(0, 0, 1, 0, 3);
    check("load_r_enable", 64'(kern_r_enable[0]), 64'd1);
    check("load_busy",     64'(busy[0]),          64'd1);
    check("load_req_ready",64'(req_ready[0]),     64'd0);
    check("load_init_a",   64'(kern_init_a[0]),   64'd1);
    tick();
    check("run_r_enable",  64'(kern_r_enable[0]), 64'd0);
    drain(100);

    send(0, 10, 1, 0, 1);
    drain(200);
    send(0, 10, 0, 1, 2);
    drain(200);

    // Back-to-back with the consumer stalled: FIFO fills and req_ready drops.
    resp_ready[0] = 1'b0;
    send(0, 2, 1, 0, 5);
    send(0, 3, 1, 0, 6);
    wait_idle(0, 200);
    check("full_req_ready", 64'(req_ready[0]),   64'd0);
    check("full_valid",     64'(resp_valid[0]),  64'd1);
    check("full_head",      64'(resp_result[0]), 64'd2);
    tick(3);
    check("head_stable",    64'(resp_tag[0]),    64'd5);
    resp_ready[0] = 1'b1;
    drain(20);
    check("drained_ready",  64'(req_ready[0]),   64'd1);
    check("drained_valid",  64'(resp_valid[0]),  64'd0);

    // Reset mid-RUN aborts the job silently.
    send(0, 10, 1, 0, 7);
    tick(10);
    check("mid_run_busy", 64'(busy[0]), 64'd1);
    rst[0] = 1'b1;
    tick();
    sb.delete();
    check("abort_valid",     64'(resp_valid[0]),    64'd0);
    check("abort_busy",      64'(busy[0]),          64'd0);
    check("abort_r_enable",  64'(kern_r_enable[0]), 64'd1);
    rst[0] = 1'b0;
    tick(70);
    check("abort_no_resp",   64'(resp_valid[0]),    64'd0);
    send(0, 4, 1, 0, 8);
    drain(100);

    // Pop of the head coincides with the next completion push.
    resp_ready[0] = 1'b0;
    send(0, 1, 1, 0, 9);
    wait_idle(0, 100);
    check("one_held_valid", 64'(resp_valid[0]), 64'd1);
    send(0, 2, 1, 0, 10);
    tick(16);
    check("pre_push_busy",  64'(busy[0]),        64'd1);
    check("pre_push_head",  64'(resp_result[0]), 64'd1);
    resp_ready[0] = 1'b1;
    tick();
    resp_ready[0] = 1'b0;
    check("swap_busy",      64'(busy[0]),        64'd0);
    check("swap_valid",     64'(resp_valid[0]),  64'd1);
    check("swap_head",      64'(resp_result[0]), 64'd2);
    check("swap_tag",       64'(resp_tag[0]),    64'd10);
    check("swap_sb_left",   64'(sb.size()),      64'd1);
    resp_ready[0] = 1'b1;
    drain(20);

    // Short watchdog: n=10 times out, then n=1 completes normally.
    send(1, 10, 1, 0, 11);
    drain(100);
    send(1, 1, 1, 0, 12);
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
